// File: rtl/myproject_mac_accum_sat_pkg.sv
// Shared types, default widths and helpers for the MAC accumulate/saturate stage.
package myproject_acc_pkg;

  typedef enum logic {
    StAcc  = 1'b0,
    StHold = 1'b1
  } acc_state_e;

  localparam int unsigned DefProdW     = 26;
  localparam int unsigned DefOutW      = 16;
  localparam int unsigned DefAccW      = 32;
  localparam int unsigned DefFracShift = 10;
  localparam int unsigned DefNTerms    = 16;

  function automatic int out_max(input int unsigned w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  function automatic int out_min(input int unsigned w);
    return -(32'sd1 <<< (w - 1));
  endfunction

  // Counter needs at least one bit even when a group is a single beat.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/myproject_mac_accum_sat_if.sv
// Product-in / result-out valid-ready bundle for the MAC accumulate/saturate stage.
interface myproject_mac_accum_sat_if #(
  parameter int unsigned PROD_W = 26,
  parameter int unsigned OUT_W  = 16
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_data;
  logic signed [OUT_W-1:0]  bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;

  modport master (
    output in_valid, in_data, bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/myproject_acc_round_sat.sv
// Shift accumulator back to output format and clamp to OUT_W signed.
// MYPROJECT_ACC_RND_EN selects round-half-up; otherwise floor (truncate).
module myproject_acc_round_sat
  import myproject_acc_pkg::*;
#(
  parameter int unsigned ACC_W      = DefAccW,
  parameter int unsigned OUT_W      = DefOutW,
  parameter int unsigned FRAC_SHIFT = DefFracShift
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    sat_o
);

  localparam logic signed [ACC_W:0] SatMax = (ACC_W + 1)'(out_max(OUT_W));
  localparam logic signed [ACC_W:0] SatMin = (ACC_W + 1)'(out_min(OUT_W));

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] shifted;

  assign acc_ext = {acc_i[ACC_W-1], acc_i};

`ifdef MYPROJECT_ACC_RND_EN
  // One extra bit keeps the half-LSB add from wrapping at the positive rail.
  localparam logic signed [ACC_W:0] RndHalf =
      (FRAC_SHIFT > 0) ? ((ACC_W + 1)'(1) << (FRAC_SHIFT - 1)) : '0;
  logic signed [ACC_W:0] acc_rnd;
  assign acc_rnd = acc_ext + RndHalf;
  assign shifted = acc_rnd >>> FRAC_SHIFT;
`else
  assign shifted = acc_ext >>> FRAC_SHIFT;
`endif

  always_comb begin
    data_o = shifted[OUT_W-1:0];
    sat_o  = 1'b0;
    if (shifted > SatMax) begin
      data_o = SatMax[OUT_W-1:0];
      sat_o  = 1'b1;
    end else if (shifted < SatMin) begin
      data_o = SatMin[OUT_W-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/myproject_mac_accum_sat.sv
// Accumulates N_TERMS signed products plus a bias, then rounds/saturates one result per group.
// Rounding mode follows MYPROJECT_ACC_RND_EN (see myproject_acc_round_sat).
module myproject_mac_accum_sat
  import myproject_acc_pkg::*;
#(
  parameter int unsigned PROD_W     = DefProdW,
  parameter int unsigned OUT_W      = DefOutW,
  parameter int unsigned ACC_W      = DefAccW,
  parameter int unsigned FRAC_SHIFT = DefFracShift,
  parameter int unsigned N_TERMS    = DefNTerms
) (
  input logic                     ap_clk,
  input logic                     ap_rst,
  myproject_mac_accum_sat_if.slave acc_if
);

  localparam int unsigned CntW = cnt_width(N_TERMS);
  localparam int unsigned NeedW =
      max_u(PROD_W, OUT_W + FRAC_SHIFT) + $clog2(N_TERMS) + 1;

  if (N_TERMS < 1) begin : g_nterms_chk
    $error("N_TERMS must be at least 1");
  end
  if (ACC_W < NeedW) begin : g_accw_chk
    $error("ACC_W too narrow for PROD_W/OUT_W/FRAC_SHIFT/N_TERMS");
  end

  acc_state_e              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic                    accept;
  logic                    last_beat;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] data_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [OUT_W-1:0] rs_data;
  logic                    rs_sat;

  assign accept    = acc_if.in_valid && (state_q == StAcc);
  assign last_beat = (cnt_q == CntW'(N_TERMS - 1));
  assign bias_ext  = {{(ACC_W - OUT_W){acc_if.bias[OUT_W-1]}}, acc_if.bias};
  assign data_ext  = {{(ACC_W - PROD_W){acc_if.in_data[PROD_W-1]}}, acc_if.in_data};
  // First beat of a group seeds the sum with the bias aligned to product fraction bits.
  assign acc_base  = (cnt_q == '0) ? (bias_ext <<< FRAC_SHIFT) : acc_q;
  assign acc_next  = acc_base + data_ext;

  myproject_acc_round_sat #(
    .ACC_W      (ACC_W),
    .OUT_W      (OUT_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_round_sat (
    .acc_i  (acc_next),
    .data_o (rs_data),
    .sat_o  (rs_sat)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    unique case (state_q)
      StAcc: begin
        if (accept) begin
          acc_d = acc_next;
          if (last_beat) begin
            cnt_d      = '0;
            state_d    = StHold;
            out_data_d = rs_data;
            out_sat_d  = rs_sat;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        if (acc_if.out_ready) begin
          state_d = StAcc;
        end
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= StAcc;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign acc_if.in_ready  = (state_q == StAcc);
  assign acc_if.out_valid = (state_q == StHold);
  assign acc_if.out_data  = out_data_q;
  assign acc_if.out_sat   = out_sat_q;

endmodule

// File: tb/tb_myproject_mac_accum_sat.sv
// Directed bench for myproject_mac_accum_sat with N_TERMS=4; expectations follow MYPROJECT_ACC_RND_EN.
module tb_myproject_mac_accum_sat;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  myproject_mac_accum_sat_if #(.PROD_W(26), .OUT_W(16)) bus ();

  myproject_mac_accum_sat #(
    .PROD_W     (26),
    .OUT_W      (16),
    .ACC_W      (32),
    .FRAC_SHIFT (10),
    .N_TERMS    (4)
  ) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .acc_if (bus)
  );

`ifdef MYPROJECT_ACC_RND_EN
  localparam logic signed [15:0] ExpPos1p5  = 16'sd2;
  localparam logic signed [15:0] ExpNeg1p5  = -16'sd1;
  localparam logic               ExpMinM1S  = 1'b0;
`else
  localparam logic signed [15:0] ExpPos1p5  = 16'sd1;
  localparam logic signed [15:0] ExpNeg1p5  = -16'sd2;
  localparam logic               ExpMinM1S  = 1'b1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Four consecutive beats; beats 1..3 carry a scrambled bias that must be ignored.
  task automatic group4(input string tag, input logic signed [15:0] b,
                        input logic signed [25:0] d0, input logic signed [25:0] d1,
                        input logic signed [25:0] d2, input logic signed [25:0] d3,
                        input logic signed [15:0] exp_d, input logic exp_s);
    logic signed [25:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      bus.bias     = (i == 0) ? b : (b ^ 16'sh5A5A);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 26'sh2AAAAAA;
      if (i < 3) check({tag, "_early_valid"}, {31'd0, bus.out_valid}, 32'd0);
    end
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_data"}, {{16{bus.out_data[15]}}, bus.out_data}, {{16{exp_d[15]}}, exp_d});
    check({tag, "_sat"}, {31'd0, bus.out_sat}, {31'd0, exp_s});
    check({tag, "_inready"}, {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.bias      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_inready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_data", {16'd0, bus.out_data}, 32'd0);
    check("rst_sat", {31'd0, bus.out_sat}, 32'd0);

    group4("basic", 16'sd0, 26'sd1024, 26'sd2048, -26'sd512, 26'sd512, 16'sd3, 1'b0);
    take("basic");
    group4("bias3", 16'sd3, 26'sd256, 26'sd256, 26'sd256, 26'sd256, 16'sd4, 1'b0);
    take("bias3");
    group4("biasneg", -16'sd5, 26'sd0, 26'sd0, 26'sd0, 26'sd0, -16'sd5, 1'b0);
    take("biasneg");
    group4("pos1p5", 16'sd0, 26'sd1024, 26'sd512, 26'sd0, 26'sd0, ExpPos1p5, 1'b0);
    take("pos1p5");
    group4("neg1p5", 16'sd0, -26'sd1024, -26'sd512, 26'sd0, 26'sd0, ExpNeg1p5, 1'b0);
    take("neg1p5");
    group4("satpos", 16'sd0, 26'sd33554431, 26'sd33554431, 26'sd33554431, 26'sd33554431,
           16'sh7FFF, 1'b1);
    take("satpos");
    group4("satneg", 16'sd0, -26'sd33554432, -26'sd33554432, -26'sd33554432,
           -26'sd33554432, -16'sh8000, 1'b1);
    take("satneg");
    group4("maxexact", 16'sd0, 26'sd33553408, 26'sd0, 26'sd0, 26'sd0, 16'sh7FFF, 1'b0);
    take("maxexact");
    group4("maxp1", 16'sd0, 26'sd33554431, 26'sd1, 26'sd0, 26'sd0, 16'sh7FFF, 1'b1);
    take("maxp1");
    group4("minexact", 16'sd0, -26'sd33554432, 26'sd0, 26'sd0, 26'sd0, -16'sh8000, 1'b0);
    take("minexact");
    group4("minm1", 16'sd0, -26'sd33554432, -26'sd1, 26'sd0, 26'sd0, -16'sh8000, ExpMinM1S);

    // Stall in HOLD with junk beats offered; nothing may move.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 26'sd999999;
      bus.bias     = 16'sd1234;
      @(posedge clk);
      #1;
      check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_data", {16'd0, bus.out_data}, 32'h0000_8000);
      check("stall_inready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    take("stall");
    group4("afterstall", 16'sd0, 26'sd1024, 26'sd1024, 26'sd0, 26'sd0, 16'sd2, 1'b0);
    take("afterstall");

    // Reset mid-group discards the partial sum.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 26'sd20000000;
      bus.bias     = 16'sd100;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_inready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_data", {16'd0, bus.out_data}, 32'd0);
    group4("postrst", 16'sd0, 26'sd1024, 26'sd1024, 26'sd1024, 26'sd1024, 16'sd4, 1'b0);
    take("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/myproject_mac_accum_sat.md
Name: myproject_mac_accum_sat

Overview:
- Downstream consumer of the 16s x 10s -> 26-bit signed product stage in the MHA datapath.
- Accumulates N_TERMS consecutive products, adds a per-dot-product bias, right-shifts back to output fixed-point format, and saturates to 16-bit signed.
- Emits one dot-product result per group on a valid/ready handshake toward the softmax/score stage.

Parameters:
- PROD_W, 26, width of incoming signed product.
- OUT_W, 16, width of signed result.
- ACC_W, 32, accumulator width; elaboration error if ACC_W < max(PROD_W, OUT_W+FRAC_SHIFT) + clog2(N_TERMS) + 1.
- FRAC_SHIFT, 10, product fraction bits discarded on output (din1 fraction bits).
- N_TERMS, 16, products per dot product (>= 1).

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  synchronous active-high reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block accepts a product this cycle.
- in_data  in  PROD_W  signed product.
- bias  in  OUT_W  signed bias in output format; sampled with the first beat of each group.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_W  signed saturated result.
- out_sat  out  1  result was clamped; qualified by out_valid.

Behaviour:
- Reset (ap_rst=1 at a clock edge): state=ACC, cnt=0, acc=0, out_valid=0, out_data=0, out_sat=0. Reset wins over every other event, including mid-group: partial sum discarded, no result emitted.
- States: ACC (accepting beats), HOLD (result presented).
- in_ready = (state==ACC). Beat accepted when in_valid && in_ready.
- On accepted beat: acc_next = (cnt==0 ? sext(bias)<<FRAC_SHIFT : acc) + sext(in_data), computed in ACC_W bits; acc <= acc_next; cnt <= cnt+1.
- On accepted beat with cnt==N_TERMS-1: out_data/out_sat <= round_sat(acc_next); out_valid <= 1; cnt <= 0; state <= HOLD. Latency: out_valid high the cycle after the last beat is accepted.
- HOLD: out_valid=1; out_data and out_sat held stable until out_valid && out_ready; then out_valid <= 0, state <= ACC. in_ready stays 0 during the handshake cycle; no bypass. Max throughput: one result per N_TERMS+1 cycles.
- round_sat: r = acc_next >>> FRAC_SHIFT (arithmetic shift, floor). If r > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1 with out_sat=1. If r < -2^(OUT_W-1), output -2^(OUT_W-1) with out_sat=1. Otherwise output r with out_sat=0.
- in_valid low mid-group: hold state and count; no timeout.
- N_TERMS==1: every accepted beat goes directly to HOLD.
- in_data and bias are ignored when no beat is accepted. No X may propagate to outputs after reset.

Optional Feature:
- Macro MYPROJECT_ACC_RND_EN.
- Defined: round half up. Add 2^(FRAC_SHIFT-1) to acc_next in ACC_W+1 bits before the arithmetic shift, then saturate.
- Undefined: truncation (floor), exactly as in Behaviour.
- Ports, latency and handshake are identical in both builds.

Decomposition:
- Package myproject_acc_pkg:
  - state enum {ACC, HOLD}
  - default width constants
  - functions for OUT_MAX/OUT_MIN saturation bounds
  - clog2 helper for counter width
- Sub-module myproject_acc_round_sat: combinational round (macro-controlled), shift and saturate. Input ACC_W, outputs OUT_W value and sat flag. Instantiated once.

Test Plan (N_TERMS=4, FRAC_SHIFT=10, defaults otherwise):
- bias=0, products 1024, 2048, -512, 512 (sum 3072) -> out_data=3, out_sat=0, out_valid 1 cycle after 4th beat.
- bias=3, products 256 x4 -> sum 3072+1024 -> out_data=4. Bias changed mid-group is ignored until the next group.
- products sum 1536 -> truncate build 1, RND build 2. Sum -1536 -> truncate -2, RND -1.
- 4 x 33554431 -> out_data=32767, out_sat=1. 4 x -33554432 -> out_data=-32768, out_sat=1.
- out_ready held low 5 cycles in HOLD -> out_data/out_sat stable, in_ready=0, in_valid ignored. After out_ready pulse -> in_ready=1 next cycle.
- 2 beats accepted, then ap_rst for 1 cycle -> out_valid=0, cnt=0. Next 4 beats of 1024 -> out_data=4 (no stale partial sum).
